// File: rtl/img2col_window_pu_if.sv
// Handshake and data bundle between the img2col window PU, its pixel source,
// the MAC array consumer and the neighbouring PU.
interface img2col_window_pu_if #(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int LANES  = 2
);
  logic                              start;
  logic                              first;
  logic                              in_valid;
  logic                              in_ready;
  logic [LANES*DATA_W-1:0]           in_data;
  logic [K*K*DATA_W-1:0]             win_out;
  logic                              out_valid;
  logic                              out_ready;
  logic [K*(K-STRIDE)*DATA_W-1:0]    nbr_out;
  logic                              nbr_valid;
  logic                              busy;

  modport master (
    output start, first, in_valid, in_data, out_ready,
    input  in_ready, win_out, out_valid, nbr_out, nbr_valid, busy
  );

  modport slave (
    input  start, first, in_valid, in_data, out_ready,
    output in_ready, win_out, out_valid, nbr_out, nbr_valid, busy
  );
endinterface

// File: rtl/img2col_window_pu.sv
// img2col processing unit: builds one KxK column-major window per round from a
// LANES-wide pixel stream, reusing overlapping columns on sliding rounds.
module img2col_window_pu #(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int LANES  = 2
) (
  input  logic               clk,
  input  logic               nrst,
  img2col_window_pu_if.slave bus
);

  localparam int N       = K * K;
  localparam int KEEP    = (K - STRIDE) * K;
  localparam int PIXW    = N * DATA_W;
  localparam int NBRW    = KEEP * DATA_W;
  localparam int CW      = $clog2(N + LANES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic [PIXW-1:0] win_q, win_d;
  logic [NBRW-1:0] nbr_q, nbr_d;
  logic            nbr_vld_q, nbr_vld_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic handshake, start_acc, beat, last_beat;

  assign handshake = (state_q == S_EMIT) && bus.out_ready;
  assign start_acc = bus.start && ((state_q == S_IDLE) || handshake);
  assign beat      = (state_q == S_LOAD) && bus.in_valid;
  // Every round, full or sliding, ends when the counter reaches K*K.
  assign last_beat = beat && ((int'(cnt_q) + LANES) >= N);

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    nbr_d     = nbr_q;
    nbr_vld_d = nbr_vld_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_LOAD;
      S_LOAD:  if (last_beat) state_d = S_EMIT;
      S_EMIT:  if (handshake) state_d = start_acc ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_acc) begin
      cnt_d = bus.first ? '0 : CW'(KEEP);
      if (!bus.first)
        win_d[0 +: NBRW] = win_q[STRIDE*K*DATA_W +: NBRW];
    end

    if (beat) begin
      for (int l = 0; l < LANES; l++) begin
        if ((int'(cnt_q) + l) < N)
          win_d[(int'(cnt_q) + l)*DATA_W +: DATA_W] = bus.in_data[l*DATA_W +: DATA_W];
      end
      cnt_d = cnt_q + CW'(LANES);
    end

    // Neighbour export sees the window including the final beat's pixels.
    if (last_beat) begin
      nbr_d     = win_d[STRIDE*K*DATA_W +: NBRW];
      nbr_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      nbr_q     <= '0;
      nbr_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      nbr_q     <= nbr_d;
      nbr_vld_q <= nbr_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.win_out   = win_q;
  assign bus.nbr_out   = nbr_q;
  assign bus.nbr_valid = nbr_vld_q;

endmodule

// File: tb/tb_img2col_window_pu.sv
// Directed bench for img2col_window_pu: default geometry (K=5,S=1,L=2) and
// a second instance with K=3,S=2,L=4.
module tb_img2col_window_pu;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  img2col_window_pu_if #(.DATA_W(16), .K(5), .STRIDE(1), .LANES(2)) ifa ();
  img2col_window_pu_if #(.DATA_W(16), .K(3), .STRIDE(2), .LANES(4)) ifb ();

  img2col_window_pu #(.DATA_W(16), .K(5), .STRIDE(1), .LANES(2)) dut_a (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifa)
  );

  img2col_window_pu #(.DATA_W(16), .K(3), .STRIDE(2), .LANES(4)) dut_b (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [25*16-1:0] expa;
  logic [20*16-1:0] expan;
  logic [9*16-1:0]  expb;
  logic [3*16-1:0]  expbn;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window for dut_a holding consecutive values base..base+24.
  task automatic set_exp_a(input int base);
    for (int i = 0; i < 25; i++) expa[i*16 +: 16] = 16'(base + i);
    for (int j = 0; j < 20; j++) expan[j*16 +: 16] = 16'(base + 5 + j);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", ifa.in_ready); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", ifa.out_valid); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", ifa.busy); end
    checks++; if (ifa.nbr_valid !== 1'b0) begin errors++; $display("FAIL rst_nbr_valid got %b exp 0", ifa.nbr_valid); end
    checks++; if (ifa.win_out !== '0) begin errors++; $display("FAIL rst_win got %h exp 0", ifa.win_out); end
    checks++; if (ifa.nbr_out !== '0) begin errors++; $display("FAIL rst_nbr got %h exp 0", ifa.nbr_out); end
    checks++; if (ifb.busy !== 1'b0 || ifb.win_out !== '0) begin errors++; $display("FAIL rst_b got busy=%b win=%h exp 0", ifb.busy, ifb.win_out); end
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    ifa.start = 1'b1; ifa.first = 1'b1;
    tick();
    ifa.start = 1'b0; ifa.first = 1'b0;
    checks++; if (ifa.busy !== 1'b1 || ifa.in_ready !== 1'b1) begin errors++; $display("FAIL full_load_enter got busy=%b in_ready=%b exp 1 1", ifa.busy, ifa.in_ready); end
    for (int b = 0; b < 13; b++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = {((b == 12) ? 16'd99 : 16'(2*b + 2)), 16'(2*b + 1)};
      if (b == 12) begin
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL full_load_early_valid got %b exp 0", ifa.out_valid); end
      end
      tick();
    end
    ifa.in_valid = 1'b0;
    set_exp_a(1);
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL full_load_out_valid got %b exp 1", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL full_load_in_ready got %b exp 0", ifa.in_ready); end
    checks++; if (ifa.win_out !== expa) begin errors++; $display("FAIL full_load_win got %h exp %h", ifa.win_out, expa); end
    checks++; if (ifa.nbr_out !== expan) begin errors++; $display("FAIL full_load_nbr got %h exp %h", ifa.nbr_out, expan); end
    checks++; if (ifa.nbr_valid !== 1'b1) begin errors++; $display("FAIL full_load_nbr_valid got %b exp 1", ifa.nbr_valid); end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) begin errors++; $display("FAIL full_load_idle got out_valid=%b busy=%b exp 0 0", ifa.out_valid, ifa.busy); end
  endtask

  task automatic test_slide();
    ifa.start = 1'b1; ifa.first = 1'b0;
    tick();
    ifa.start = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_data = {16'd27, 16'd26}; tick();
    ifa.in_data = {16'd29, 16'd28}; tick();
    ifa.in_data = {16'd77, 16'd30}; tick();
    ifa.in_valid = 1'b0;
    set_exp_a(6);
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL slide_out_valid got %b exp 1", ifa.out_valid); end
    checks++; if (ifa.win_out !== expa) begin errors++; $display("FAIL slide_win got %h exp %h", ifa.win_out, expa); end
    checks++; if (ifa.nbr_out !== expan) begin errors++; $display("FAIL slide_nbr got %h exp %h", ifa.nbr_out, expan); end
  endtask

  task automatic test_backpressure();
    set_exp_a(6);
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = {16'hAAAA, 16'hBBBB};
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (ifa.out_valid !== 1'b1 || ifa.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got out_valid=%b in_ready=%b exp 1 0", c, ifa.out_valid, ifa.in_ready); end
      checks++; if (ifa.win_out !== expa) begin errors++; $display("FAIL bp_win_%0d got %h exp %h", c, ifa.win_out, expa); end
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b0;
    checks++; if (ifa.busy !== 1'b0 || ifa.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%b out_valid=%b exp 0 0", ifa.busy, ifa.out_valid); end
    checks++; if (ifa.win_out !== expa) begin errors++; $display("FAIL bp_no_consume got %h exp %h", ifa.win_out, expa); end
  endtask

  task automatic test_back_to_back();
    int r;
    int ph;
    int base;
    ifa.start = 1'b1; ifa.first = 1'b0; ifa.out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      r  = (c - 1) / 4;
      ph = (c - 1) % 4;
      base = 31 + 5*r + 2*(ph - 1);
      ifa.in_valid = (ph != 0);
      ifa.in_data  = {16'(base + 1), 16'(base)};
      tick();
      checks++;
      if (ifa.out_valid !== ((c % 4) == 0)) begin
        errors++; $display("FAIL b2b_cycle_%0d out_valid got %b exp %b", c, ifa.out_valid, ((c % 4) == 0));
      end
    end
    ifa.start = 1'b0; ifa.in_valid = 1'b0;
    set_exp_a(21);
    checks++; if (ifa.win_out !== expa) begin errors++; $display("FAIL b2b_win got %h exp %h", ifa.win_out, expa); end
    checks++; if (ifa.nbr_out !== expan) begin errors++; $display("FAIL b2b_nbr got %h exp %h", ifa.nbr_out, expan); end
    tick();
    ifa.out_ready = 1'b0;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", ifa.busy); end
  endtask

  task automatic test_async_reset();
    ifa.start = 1'b1; ifa.first = 1'b1;
    tick();
    ifa.start = 1'b0;
    ifa.in_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      ifa.in_data = {16'(100 + 2*b + 1), 16'(100 + 2*b)};
      tick();
    end
    #3;
    nrst = 1'b0;
    #1;
    checks++; if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) begin errors++; $display("FAIL arst_ctrl got in_ready=%b out_valid=%b busy=%b exp 0 0 0", ifa.in_ready, ifa.out_valid, ifa.busy); end
    checks++; if (ifa.win_out !== '0) begin errors++; $display("FAIL arst_win got %h exp 0", ifa.win_out); end
    checks++; if (ifa.nbr_out !== '0) begin errors++; $display("FAIL arst_nbr got %h exp 0", ifa.nbr_out); end
    checks++; if (ifa.nbr_valid !== 1'b0) begin errors++; $display("FAIL arst_nbr_valid got %b exp 0", ifa.nbr_valid); end
    ifa.in_valid = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_params_b();
    for (int i = 0; i < 9; i++) expb[i*16 +: 16] = 16'(i + 1);
    for (int j = 0; j < 3; j++) expbn[j*16 +: 16] = 16'(7 + j);
    ifb.start = 1'b1; ifb.first = 1'b1;
    tick();
    ifb.start = 1'b0;
    ifb.in_valid = 1'b1;
    ifb.in_data = {16'd4, 16'd3, 16'd2, 16'd1}; tick();
    ifb.in_data = {16'd8, 16'd7, 16'd6, 16'd5}; tick();
    checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL b_full_early_valid got %b exp 0", ifb.out_valid); end
    ifb.in_data = {16'd55, 16'd55, 16'd55, 16'd9}; tick();
    ifb.in_valid = 1'b0;
    checks++; if (ifb.out_valid !== 1'b1) begin errors++; $display("FAIL b_full_out_valid got %b exp 1", ifb.out_valid); end
    checks++; if (ifb.win_out !== expb) begin errors++; $display("FAIL b_full_win got %h exp %h", ifb.win_out, expb); end
    checks++; if (ifb.nbr_out !== expbn) begin errors++; $display("FAIL b_full_nbr got %h exp %h", ifb.nbr_out, expbn); end
    ifb.out_ready = 1'b1;
    tick();
    ifb.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) expb[i*16 +: 16] = 16'(i + 7);
    for (int j = 0; j < 3; j++) expbn[j*16 +: 16] = 16'(13 + j);
    ifb.start = 1'b1; ifb.first = 1'b0;
    tick();
    ifb.start = 1'b0;
    ifb.in_valid = 1'b1;
    ifb.in_data = {16'd13, 16'd12, 16'd11, 16'd10}; tick();
    checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL b_slide_early_valid got %b exp 0", ifb.out_valid); end
    ifb.in_data = {16'd66, 16'd66, 16'd15, 16'd14}; tick();
    ifb.in_valid = 1'b0;
    checks++; if (ifb.out_valid !== 1'b1) begin errors++; $display("FAIL b_slide_out_valid got %b exp 1", ifb.out_valid); end
    checks++; if (ifb.win_out !== expb) begin errors++; $display("FAIL b_slide_win got %h exp %h", ifb.win_out, expb); end
    checks++; if (ifb.nbr_out !== expbn) begin errors++; $display("FAIL b_slide_nbr got %h exp %h", ifb.nbr_out, expbn); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ifa.start = 1'b0; ifa.first = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.start = 1'b0; ifb.first = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    test_reset();
    test_full_load();
    test_slide();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_params_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
